// File: rtl/regfile_mp.sv
// ----------------------------------------------------------------------------
// regfile_mp
//
// Multi-port integer register file with a per-register busy-bit scoreboard.
// Register 0 has no storage: it always reads zero and ignores writes and
// reservations.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   -> same-cycle write data is forwarded to matching read ports,
//                and rbusy is cleared for them unless the same address is
//                being reserved in that cycle.
//   undefined -> reads and rbusy reflect stored state only. There is no
//                combinational path from wen/wdata to rdata/rbusy.
//
// Parameters:
//   DEPTH  number of architectural registers (power of two, >= 2)
//   BITS   data width
//   RPORTS number of read ports (>= 1)
//   WPORTS number of write ports (>= 1)
//
// Ports:
//   clk       clock; all state updates on the rising edge
//   rst_n     asynchronous active-low reset; clears all data and busy bits
//   raddr     RPORTS*AW read addresses, port p at [p*AW +: AW]
//   rdata     RPORTS*BITS combinational read data, port p at [p*BITS +: BITS]
//   rbusy     RPORTS busy flags of each port's source register
//   wen       WPORTS write enables
//   waddr     WPORTS*AW write addresses
//   wdata     WPORTS*BITS write data
//   rsv_en    reserve rsv_addr (a producer was issued)
//   rsv_addr  register being reserved
//   flush     clear every busy bit; overrides rsv_en in the same cycle
// ----------------------------------------------------------------------------
module regfile_mp #(
    parameter int DEPTH  = 32,
    parameter int BITS   = 64,
    parameter int RPORTS = 2,
    parameter int WPORTS = 1,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [RPORTS*AW-1:0]     raddr,
    output logic [RPORTS*BITS-1:0]   rdata,
    output logic [RPORTS-1:0]        rbusy,
    input  logic [WPORTS-1:0]        wen,
    input  logic [WPORTS*AW-1:0]     waddr,
    input  logic [WPORTS*BITS-1:0]   wdata,
    input  logic                     rsv_en,
    input  logic [AW-1:0]            rsv_addr,
    input  logic                     flush
);

    // Read-side view of the state, with entry 0 tied to zero so read ports
    // can index with the raw address and need no special case for r0.
    logic [BITS-1:0] rd_view   [DEPTH];
    logic            busy_view [DEPTH];

    assign rd_view[0]   = '0;
    assign busy_view[0] = 1'b0;

    // ------------------------------------------------------------------
    // Storage and scoreboard, one slice per architectural register 1..DEPTH-1
    // ------------------------------------------------------------------
    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_reg
        logic [BITS-1:0] data_d;
        logic [BITS-1:0] data_q;
        logic            busy_d;
        logic            busy_q;
        logic            wr_hit;

        always_comb begin
            data_d = data_q;
            wr_hit = 1'b0;
            // Ascending scan: the highest-index matching port is applied last
            // and therefore wins.
            for (int w = 0; w < WPORTS; w++) begin
                if (wen[w] && (waddr[w*AW +: AW] == AW'(gi))) begin
                    data_d = wdata[w*BITS +: BITS];
                    wr_hit = 1'b1;
                end
            end

            // Priority: flush > reservation > write-back clear > hold.
            // A reservation beats a same-cycle write because a newer
            // producer is already in flight for this register.
            if (flush) begin
                busy_d = 1'b0;
            end else if (rsv_en && (rsv_addr == AW'(gi))) begin
                busy_d = 1'b1;
            end else if (wr_hit) begin
                busy_d = 1'b0;
            end else begin
                busy_d = busy_q;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q <= '0;
                busy_q <= 1'b0;
            end else begin
                data_q <= data_d;
                busy_q <= busy_d;
            end
        end

        assign rd_view[gi]   = data_q;
        assign busy_view[gi] = busy_q;
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < RPORTS; gi++) begin : g_rport
        logic [AW-1:0]   addr;
        logic [BITS-1:0] rd_val;
        logic            rb_val;

        assign addr = raddr[gi*AW +: AW];

`ifdef REGFILE_BYPASS_EN
        logic byp_hit;

        always_comb begin
            rd_val  = rd_view[addr];
            rb_val  = busy_view[addr];
            byp_hit = 1'b0;
            for (int w = 0; w < WPORTS; w++) begin
                if (wen[w] && (addr != '0) && (waddr[w*AW +: AW] == addr)) begin
                    rd_val  = wdata[w*BITS +: BITS];
                    byp_hit = 1'b1;
                end
            end
            // A same-cycle reservation of this address lands next cycle, so
            // the stored busy bit is reported unchanged in that case.
            if (byp_hit && !(rsv_en && (rsv_addr == addr))) begin
                rb_val = 1'b0;
            end
        end
`else
        always_comb begin
            rd_val = rd_view[addr];
            rb_val = busy_view[addr];
        end
`endif

        assign rdata[gi*BITS +: BITS] = rd_val;
        assign rbusy[gi]              = rb_val;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file with an integrated busy-bit scoreboard. It is the next-generation replacement for the single-write, dual-read register file in the pipeline's decode stage, generalised to RPORTS read ports and WPORTS write ports. It adds an asynchronous reset of all architectural state and per-register busy tracking for hazard detection. Register 0 is hardwired to zero.

## Interface
- DEPTH, 32, number of architectural registers (power of two, ≥2)
- BITS, 64, data width
- RPORTS, 2, number of read ports (≥1)
- WPORTS, 1, number of write ports (≥1)
- AW (localparam), $clog2(DEPTH), address width
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- raddr  in  RPORTS*AW  read addresses; port p uses bits [p*AW +: AW]
- rdata  out  RPORTS*BITS  read data; port p uses bits [p*BITS +: BITS]
- rbusy  out  RPORTS  port p source register has a pending write
- wen  in  WPORTS  write enable per write port
- waddr  in  WPORTS*AW  write addresses
- wdata  in  WPORTS*BITS  write data
- rsv_en  in  1  reserve destination register (issue of a producer)
- rsv_addr  in  AW  register being reserved
- flush  in  1  clear all busy bits (pipeline flush)

## Operation
- Storage: DEPTH-1 registers of BITS (index 1..DEPTH-1); index 0 has no storage, reads 0, and ignores writes and reservations.
- Reads: combinational. rdata[p] = reg[raddr[p]] (0 for address 0). Any number of ports may read the same address.
- Writes: on the rising edge, for each port w with wen[w]=1 and waddr[w]≠0, reg[waddr[w]] ← wdata[w]. When several ports write the same address in one cycle, the highest-index port wins.
- Scoreboard: one busy bit per register (bit 0 constant 0).
  - On a rising edge with rsv_en=1 and rsv_addr≠0: busy[rsv_addr] ← 1.
  - On a rising edge with wen[w]=1 and waddr[w]≠0: busy[waddr[w]] ← 0.
  - Same address reserved and written in one cycle: the reservation wins, so busy stays 1 because a new producer is in flight.
  - flush=1 clears every busy bit and overrides rsv_en in that cycle. Writes in a flush cycle still update data.
- rbusy[p] = busy[raddr[p]], masked as described under Configuration.

## Timing
- Read latency 0 cycles (combinational from raddr and state). Write latency 1 cycle.
- Reset (rst_n=0, asynchronous assert; deassert is sampled on clk): all registers 0, all busy bits 0. Consequently rdata=0 and rbusy=0 for every port.
- Reset asserted mid-cycle aborts any pending write and reservation. Nothing from that cycle is committed.
- A reservation is visible on rbusy the cycle after rsv_en. Clearing is visible the cycle after the write unless bypass is enabled.
- No handshake: the block never stalls, and callers gate issue on rbusy.

## Configuration
- REGFILE_BYPASS_EN defined:
  - A read whose address matches an active same-cycle write (wen=1, address≠0) returns that wdata combinationally, using the highest-index matching write port.
  - rbusy for that port is forced to 0 in that cycle, unless rsv_en targets the same address. In that case rbusy still reflects stored busy, because the reservation only lands next cycle.
- REGFILE_BYPASS_EN undefined:
  - Same-cycle read returns the old stored value.
  - rbusy reflects only stored busy bits.
- Without the macro, the block has no combinational path from wdata/wen to rdata/rbusy.

## Test plan
- Reset: write 0xDEAD to r5, then assert rst_n=0 mid-cycle -> rdata for r5 reads 0 immediately and rbusy=0 on all ports.
- r0 protection: wen[0]=1, waddr=0, wdata=0xFFFF, rsv_en=1, rsv_addr=0 -> next cycle raddr=0 gives rdata=0 and rbusy=0.
- Write-port priority: WPORTS=2, both ports write r7 with 0x11 (port 0) and 0x22 (port 1) -> r7=0x22.
- Scoreboard: reserve r3 -> rbusy=1 next cycle. Write r3=0x5 and reserve r3 in the same cycle -> rbusy remains 1 and r3=0x5. Write r3 again with no reservation -> rbusy=0 next cycle.
- Flush: reserve r1, r2, r4, then flush=1 together with rsv_en for r6 -> the next cycle shows all busy bits 0, including r6.
- Bypass: read r9 while writing r9=0xABCD in the same cycle -> with REGFILE_BYPASS_EN, rdata=0xABCD and rbusy=0; without it, rdata shows the old value and 0xABCD appears next cycle.
